hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//  Pipeline sequencer for the 5-stage core: drives stall/flush of the IF/ID and ID/EX registers (flush_EX -> ID/EX clr),
//  a global freeze of EX/MEM/WB during data-memory wait states, and EX operand forwarding selects.
//  Tracks init, memory wait and memory-timeout error in an FSM.
// PARAMETERS
//  MEM_TIMEOUT   16  max wait cycles for memReady before error; 0 = no timeout
//  PERF_W        32  width of performance counters (HAZARD_PERF_CNT_EN only)
// PORTS
//  clk              in   1   core clock, all state on rising edge
//  rst_n            in   1   asynchronous active-low reset
//  readAddress1_ID  in   5   rs1 in ID;  readAddress2_ID in 5 rs2 in ID
//  readAddress1_EX  in   5   rs1 in EX;  readAddress2_EX in 5 rs2 in EX
//  writeAddress_EX  in   5   rd in EX;   regWrite_EX in 1;  resultSrc_EX in 2 (RES_MEM=2'b01 marks a load)
//  writeAddress_MEM in   5   rd in MEM;  regWrite_MEM in 1;  memReq_MEM in 1 load/store in MEM
//  writeAddress_WB  in   5   rd in WB;   regWrite_WB in 1
//  PCSrc_EX         in   1   taken branch/jump resolved in EX
//  memReady         in   1   data memory access complete this cycle
//  stall_IF, stall_ID  out 1  hold PC / IF-ID register
//  flush_ID, flush_EX  out 1  clear IF-ID / ID-EX register next edge
//  freeze           out  1   hold ID-EX, EX-MEM, MEM-WB registers
//  forwardA_EX, forwardB_EX out 2  FWD_NONE=00, FWD_WB=01, FWD_MEM=10
//  memErr           out  1   sticky memory-timeout error
//  stallCycles, flushCycles out PERF_W  performance counters
// BEHAVIOUR
//  Async reset: state=INIT, waitCnt=0, counters=0. While rst_n low: stall_IF=stall_ID=1, flush_ID=flush_EX=1, freeze=0, fwd=00, memErr=0.
//  Outputs combinational from state + inputs; zero added latency.
//  memWait = memReq_MEM & ~memReady.  loadUse = regWrite_EX & resultSrc_EX==RES_MEM & writeAddress_EX!=0
//   & (writeAddress_EX==readAddress1_ID | writeAddress_EX==readAddress2_ID).
//  INIT (1 cycle after reset release): stall_IF=1, flush_ID=flush_EX=1 -> RUN.
//  RUN, priority memWait > PCSrc_EX > loadUse:
//   memWait: stall_IF=stall_ID=freeze=1, flushes 0; -> MEMWAIT, waitCnt=1.
//   PCSrc_EX: flush_ID=flush_EX=1, no stall (branch overrides a same-cycle load-use).
//   loadUse: stall_IF=stall_ID=1, flush_EX=1 (one bubble; load moves to MEM so it self-clears).
//  MEMWAIT: freeze held while memReady=0, waitCnt++; memReady=1 -> freeze drops same cycle, -> RUN, waitCnt=0.
//   Flushes suppressed while frozen; a pending PCSrc_EX stays held in EX and flushes on the release cycle.
//   MEM_TIMEOUT>0 & waitCnt==MEM_TIMEOUT & memReady=0 -> ERR.
//  ERR: freeze=stall_IF=stall_ID=1, memErr=1; exit only via rst_n. Reset mid-wait returns to INIT.
//  Forwarding (per operand, rsX_EX): MEM if regWrite_MEM & wa_MEM!=0 & wa_MEM==rsX; else WB if regWrite_WB & wa_WB!=0
//   & wa_WB==rsX; else NONE. MEM beats WB on equal rd; x0 never forwarded. Unaffected by FSM state.
// CONFIGURATION
//  HAZARD_PERF_CNT_EN defined: stallCycles++ each cycle stall_ID=1; flushCycles++ each cycle flush_EX=1 (outside INIT);
//   both saturate at all-ones. Undefined: counters absent, outputs tied 0.
// STRUCTURE
//  pipe_ctrl_pkg: RES_MEM encoding, FWD_NONE/FWD_WB/FWD_MEM, FSM state encoding (INIT, RUN, MEMWAIT, ERR).
//  Sub-module fwd_select (combinational comparator), instantiated for operand A and B.
// TESTING
//  Reset: rst_n low then high -> one INIT cycle with flush_ID=flush_EX=1, then all outputs 0 in RUN.
//  Load-use: lw x5 in EX, ID reads x5 -> stall_IF=stall_ID=flush_EX=1 for exactly 1 cycle; rd=x0 -> no stall.
//  Branch + load-use same cycle: PCSrc_EX=1, loadUse=1 -> flush_ID=flush_EX=1, stall_ID=0.
//  Forwarding: rd_MEM=rd_WB=x7=rs1_EX, both regWrite -> forwardA_EX=10; MEM regWrite=0 -> 01.
//  Mem wait: memReady low 3 cycles -> freeze=1 for 3 cycles, drops with memReady; PCSrc_EX held -> flush on release.
//  Timeout: MEM_TIMEOUT=4, memReady stuck 0 -> ERR, memErr=1 sticky until rst_n; perf counters match stall/flush cycles.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: result source, forward selects,
// controller states and the register-hit helper used by load-use and forwarding checks.
package pipe_ctrl_pkg;

  localparam logic [1:0] RES_MEM  = 2'b01;

  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_WB   = 2'b01;
  localparam logic [1:0] FWD_MEM  = 2'b10;

  typedef enum logic [1:0] {
    ST_INIT    = 2'b00,
    ST_RUN     = 2'b01,
    ST_MEMWAIT = 2'b10,
    ST_ERR     = 2'b11
  } state_e;

  // A writer only matches when it writes a real register; x0 never counts as a producer.
  function automatic logic rd_hit(input logic we, input logic [4:0] rd, input logic [4:0] rs);
    return we & (rd != 5'd0) & (rd == rs);
  endfunction

endpackage

// File: rtl/fwd_select.sv
// EX-stage operand forward select: the younger MEM-stage producer wins over WB.
module fwd_select
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] rs_i,
  input  logic       wr_mem_i,
  input  logic [4:0] wa_mem_i,
  input  logic       wr_wb_i,
  input  logic [4:0] wa_wb_i,
  output logic [1:0] fwd_o
);

  always_comb begin
    fwd_o = FWD_NONE;
    if (rd_hit(wr_mem_i, wa_mem_i, rs_i)) begin
      fwd_o = FWD_MEM;
    end else if (rd_hit(wr_wb_i, wa_wb_i, rs_i)) begin
      fwd_o = FWD_WB;
    end else begin
      fwd_o = FWD_NONE;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// 5-stage pipeline hazard controller: stall/flush/freeze sequencing, memory-wait FSM with
// timeout error, and EX forwarding. Define HAZARD_PERF_CNT_EN to build the perf counters.
module hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int PERF_W      = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [4:0]        readAddress1_ID,
  input  logic [4:0]        readAddress2_ID,
  input  logic [4:0]        readAddress1_EX,
  input  logic [4:0]        readAddress2_EX,
  input  logic [4:0]        writeAddress_EX,
  input  logic              regWrite_EX,
  input  logic [1:0]        resultSrc_EX,
  input  logic [4:0]        writeAddress_MEM,
  input  logic              regWrite_MEM,
  input  logic              memReq_MEM,
  input  logic [4:0]        writeAddress_WB,
  input  logic              regWrite_WB,
  input  logic              PCSrc_EX,
  input  logic              memReady,
  output logic              stall_IF,
  output logic              stall_ID,
  output logic              flush_ID,
  output logic              flush_EX,
  output logic              freeze,
  output logic [1:0]        forwardA_EX,
  output logic [1:0]        forwardB_EX,
  output logic              memErr,
  output logic [PERF_W-1:0] stallCycles,
  output logic [PERF_W-1:0] flushCycles
);

  localparam int              CNT_W     = $clog2(MEM_TIMEOUT + 2);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  state_e           state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             hold_s;
  logic             load_use_s;
  logic             load_ex_s;

  assign load_ex_s  = regWrite_EX & (resultSrc_EX == RES_MEM);
  assign load_use_s = rd_hit(load_ex_s, writeAddress_EX, readAddress1_ID)
                    | rd_hit(load_ex_s, writeAddress_EX, readAddress2_ID);

  // Once in MEMWAIT the access is already committed, so only memReady matters.
  assign hold_s = ((state_q == ST_RUN) & memReq_MEM & ~memReady)
                | ((state_q == ST_MEMWAIT) & ~memReady);

  always_comb begin
    stall_IF = 1'b0;
    stall_ID = 1'b0;
    flush_ID = 1'b0;
    flush_EX = 1'b0;
    freeze   = 1'b0;
    memErr   = 1'b0;
    case (state_q)
      ST_INIT: begin
        stall_IF = 1'b1;
        stall_ID = 1'b1;
        flush_ID = 1'b1;
        flush_EX = 1'b1;
      end
      ST_RUN, ST_MEMWAIT: begin
        if (hold_s) begin
          stall_IF = 1'b1;
          stall_ID = 1'b1;
          freeze   = 1'b1;
        end else if (PCSrc_EX) begin
          flush_ID = 1'b1;
          flush_EX = 1'b1;
        end else if (load_use_s) begin
          stall_IF = 1'b1;
          stall_ID = 1'b1;
          flush_EX = 1'b1;
        end else begin
          stall_IF = 1'b0;
        end
      end
      ST_ERR: begin
        stall_IF = 1'b1;
        stall_ID = 1'b1;
        freeze   = 1'b1;
        memErr   = 1'b1;
      end
      default: begin
        stall_IF = 1'b1;
        stall_ID = 1'b1;
        flush_ID = 1'b1;
        flush_EX = 1'b1;
      end
    endcase
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      ST_INIT: begin
        state_d    = ST_RUN;
        wait_cnt_d = '0;
      end
      ST_RUN: begin
        if (hold_s) begin
          state_d    = ST_MEMWAIT;
          wait_cnt_d = CNT_W'(1);
        end else begin
          wait_cnt_d = '0;
        end
      end
      ST_MEMWAIT: begin
        if (memReady) begin
          state_d    = ST_RUN;
          wait_cnt_d = '0;
        end else if ((MEM_TIMEOUT > 0) && (wait_cnt_q == TIMEOUT_C)) begin
          state_d    = ST_ERR;
        end else if (wait_cnt_q != CNT_MAX) begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end else begin
          wait_cnt_d = wait_cnt_q;
        end
      end
      ST_ERR: begin
        state_d = ST_ERR;
      end
      default: begin
        state_d    = ST_INIT;
        wait_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_INIT;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  fwd_select u_fwd_a (
    .rs_i     (readAddress1_EX),
    .wr_mem_i (regWrite_MEM),
    .wa_mem_i (writeAddress_MEM),
    .wr_wb_i  (regWrite_WB),
    .wa_wb_i  (writeAddress_WB),
    .fwd_o    (forwardA_EX)
  );

  fwd_select u_fwd_b (
    .rs_i     (readAddress2_EX),
    .wr_mem_i (regWrite_MEM),
    .wa_mem_i (writeAddress_MEM),
    .wr_wb_i  (regWrite_WB),
    .wa_wb_i  (writeAddress_WB),
    .fwd_o    (forwardB_EX)
  );

`ifdef HAZARD_PERF_CNT_EN
  logic [PERF_W-1:0] stall_cnt_q;
  logic [PERF_W-1:0] flush_cnt_q;
  logic              count_en_s;

  assign count_en_s = (state_q != ST_INIT);

  // Saturating counters; the reset-time INIT bubble is not a hazard and is not counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (count_en_s && stall_ID && (stall_cnt_q != {PERF_W{1'b1}})) begin
        stall_cnt_q <= stall_cnt_q + PERF_W'(1);
      end
      if (count_en_s && flush_EX && (flush_cnt_q != {PERF_W{1'b1}})) begin
        flush_cnt_q <= flush_cnt_q + PERF_W'(1);
      end
    end
  end

  assign stallCycles = stall_cnt_q;
  assign flushCycles = flush_cnt_q;
`else
  assign stallCycles = '0;
  assign flushCycles = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized cycles
// compared against a cycle-level behavioural model of the hazard rules.
module tb_hazard_ctrl;

  localparam int TO = 4;
  localparam int PW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [4:0]    readAddress1_ID, readAddress2_ID, readAddress1_EX, readAddress2_EX;
  logic [4:0]    writeAddress_EX, writeAddress_MEM, writeAddress_WB;
  logic          regWrite_EX, regWrite_MEM, regWrite_WB;
  logic [1:0]    resultSrc_EX;
  logic          memReq_MEM, PCSrc_EX, memReady;
  logic          stall_IF, stall_ID, flush_ID, flush_EX, freeze, memErr;
  logic [1:0]    forwardA_EX, forwardB_EX;
  logic [PW-1:0] stallCycles, flushCycles;

  int tests = 0;
  int fails = 0;

  wire [5:0] ctl = {stall_IF, stall_ID, flush_ID, flush_EX, freeze, memErr};

  always #5 clk = ~clk;

  hazard_ctrl #(.MEM_TIMEOUT(TO), .PERF_W(PW)) dut (
    .clk(clk), .rst_n(rst_n),
    .readAddress1_ID(readAddress1_ID), .readAddress2_ID(readAddress2_ID),
    .readAddress1_EX(readAddress1_EX), .readAddress2_EX(readAddress2_EX),
    .writeAddress_EX(writeAddress_EX), .regWrite_EX(regWrite_EX), .resultSrc_EX(resultSrc_EX),
    .writeAddress_MEM(writeAddress_MEM), .regWrite_MEM(regWrite_MEM), .memReq_MEM(memReq_MEM),
    .writeAddress_WB(writeAddress_WB), .regWrite_WB(regWrite_WB),
    .PCSrc_EX(PCSrc_EX), .memReady(memReady),
    .stall_IF(stall_IF), .stall_ID(stall_ID), .flush_ID(flush_ID), .flush_EX(flush_EX),
    .freeze(freeze), .forwardA_EX(forwardA_EX), .forwardB_EX(forwardB_EX),
    .memErr(memErr), .stallCycles(stallCycles), .flushCycles(flushCycles)
  );

  task automatic set_idle();
    readAddress1_ID = 5'd0; readAddress2_ID = 5'd0;
    readAddress1_EX = 5'd0; readAddress2_EX = 5'd0;
    writeAddress_EX = 5'd0; regWrite_EX = 1'b0; resultSrc_EX = 2'b00;
    writeAddress_MEM = 5'd0; regWrite_MEM = 1'b0; memReq_MEM = 1'b0;
    writeAddress_WB = 5'd0; regWrite_WB = 1'b0;
    PCSrc_EX = 1'b0; memReady = 1'b1;
  endtask

  task automatic test_reset();
    set_idle();
    rst_n = 1'b0;
    @(negedge clk); #1;
    tests++;
    if (ctl !== 6'b111100 || forwardA_EX !== 2'b00 || forwardB_EX !== 2'b00) begin
      fails++;
      $display("FAIL reset_hold: ctl=%b fwd=%b/%b expected ctl=111100 fwd=00/00", ctl, forwardA_EX, forwardB_EX);
    end
    tests++;
    if (stallCycles !== '0 || flushCycles !== '0) begin
      fails++;
      $display("FAIL reset_counters: stall=%0d flush=%0d expected 0/0", stallCycles, flushCycles);
    end
    @(negedge clk); rst_n = 1'b1; #1;
    tests++;
    if (ctl !== 6'b111100) begin
      fails++;
      $display("FAIL init_cycle: ctl=%b expected 111100", ctl);
    end
    @(negedge clk); #1;
    tests++;
    if (ctl !== 6'b000000) begin
      fails++;
      $display("FAIL run_idle: ctl=%b expected 000000", ctl);
    end
  endtask

  task automatic test_load_use();
    logic [5:0] exp;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); set_idle();
      case (k)
        0: begin regWrite_EX = 1'b1; resultSrc_EX = 2'b01; writeAddress_EX = 5'd5; readAddress1_ID = 5'd5; exp = 6'b110100; end
        1: begin readAddress1_ID = 5'd5; exp = 6'b000000; end
        2: begin regWrite_EX = 1'b1; resultSrc_EX = 2'b01; writeAddress_EX = 5'd0; readAddress2_ID = 5'd0; exp = 6'b000000; end
        3: begin regWrite_EX = 1'b1; resultSrc_EX = 2'b01; writeAddress_EX = 5'd12; readAddress2_ID = 5'd12; exp = 6'b110100; end
        default: begin regWrite_EX = 1'b1; resultSrc_EX = 2'b00; writeAddress_EX = 5'd12; readAddress1_ID = 5'd12; exp = 6'b000000; end
      endcase
      #1;
      tests++;
      if (ctl !== exp) begin
        fails++;
        $display("FAIL load_use[%0d]: ctl=%b expected %b", k, ctl, exp);
      end
    end
  endtask

  task automatic test_branch_loaduse();
    @(negedge clk); set_idle();
    regWrite_EX = 1'b1; resultSrc_EX = 2'b01; writeAddress_EX = 5'd8; readAddress1_ID = 5'd8; PCSrc_EX = 1'b1;
    #1;
    tests++;
    if (ctl !== 6'b001100) begin
      fails++;
      $display("FAIL branch_over_loaduse: ctl=%b expected 001100", ctl);
    end
    @(negedge clk); set_idle(); #1;
    tests++;
    if (ctl !== 6'b000000) begin
      fails++;
      $display("FAIL branch_after: ctl=%b expected 000000", ctl);
    end
  endtask

  task automatic test_forwarding();
    logic [1:0] ea, eb;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); set_idle();
      case (k)
        0: begin readAddress1_EX = 5'd7; readAddress2_EX = 5'd7; writeAddress_MEM = 5'd7; regWrite_MEM = 1'b1;
                 writeAddress_WB = 5'd7; regWrite_WB = 1'b1; ea = 2'b10; eb = 2'b10; end
        1: begin readAddress1_EX = 5'd7; readAddress2_EX = 5'd7; writeAddress_MEM = 5'd7; regWrite_MEM = 1'b0;
                 writeAddress_WB = 5'd7; regWrite_WB = 1'b1; ea = 2'b01; eb = 2'b01; end
        2: begin readAddress1_EX = 5'd0; readAddress2_EX = 5'd9; writeAddress_MEM = 5'd0; regWrite_MEM = 1'b1;
                 writeAddress_WB = 5'd0; regWrite_WB = 1'b1; ea = 2'b00; eb = 2'b00; end
        default: begin readAddress1_EX = 5'd6; readAddress2_EX = 5'd4; writeAddress_MEM = 5'd6; regWrite_MEM = 1'b1;
                 writeAddress_WB = 5'd4; regWrite_WB = 1'b1; ea = 2'b10; eb = 2'b01; end
      endcase
      #1;
      tests++;
      if (forwardA_EX !== ea || forwardB_EX !== eb) begin
        fails++;
        $display("FAIL forwarding[%0d]: fwdA=%b fwdB=%b expected %b/%b", k, forwardA_EX, forwardB_EX, ea, eb);
      end
    end
  endtask

  task automatic test_mem_wait();
    logic [5:0] exp;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); set_idle();
      if (k < 4) begin
        memReq_MEM = 1'b1;
        PCSrc_EX   = 1'b1;
        memReady   = (k == 3);
      end
      exp = (k < 3) ? 6'b110010 : (k == 3) ? 6'b001100 : 6'b000000;
      #1;
      tests++;
      if (ctl !== exp) begin
        fails++;
        $display("FAIL mem_wait[%0d]: ctl=%b expected %b", k, ctl, exp);
      end
    end
  endtask

  task automatic test_timeout();
    logic [5:0] exp;
    int es, ef;
    @(negedge clk); set_idle(); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 9; k++) begin
      if (k != 0) @(negedge clk);
      set_idle();
      if (k == 0) PCSrc_EX = 1'b1;
      else begin
        memReq_MEM = (k <= 5);
        memReady   = (k == 8);
      end
      if (k == 7) begin readAddress1_EX = 5'd3; writeAddress_WB = 5'd3; regWrite_WB = 1'b1; end
      exp = (k == 0) ? 6'b001100 : (k <= 5) ? 6'b110010 : 6'b110011;
      #1;
      tests++;
      if (ctl !== exp || (k == 7 && forwardA_EX !== 2'b01)) begin
        fails++;
        $display("FAIL timeout[%0d]: ctl=%b fwdA=%b expected %b", k, ctl, forwardA_EX, exp);
      end
    end
    @(negedge clk); set_idle(); #1;
`ifdef HAZARD_PERF_CNT_EN
    es = 8; ef = 1;
`else
    es = 0; ef = 0;
`endif
    tests++;
    if (stallCycles !== PW'(es) || flushCycles !== PW'(ef) || memErr !== 1'b1) begin
      fails++;
      $display("FAIL timeout_counters: stall=%0d flush=%0d memErr=%b expected %0d/%0d/1", stallCycles, flushCycles, memErr, es, ef);
    end
    @(negedge clk); rst_n = 1'b0; #1;
    tests++;
    if (ctl !== 6'b111100) begin
      fails++;
      $display("FAIL err_reset: ctl=%b expected 111100", ctl);
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); #1;
    tests++;
    if (ctl !== 6'b000000) begin
      fails++;
      $display("FAIL err_cleared: ctl=%b expected 000000", ctl);
    end
  endtask

  task automatic test_random();
    bit         m_init, m_err, mw, lu;
    int         m_wait, m_stalls, m_flushes, es, ef;
    logic [5:0] exp;
    logic [1:0] ea, eb;
    for (int r = 0; r < 4; r++) begin
      @(negedge clk); set_idle(); rst_n = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      m_init = 1'b1; m_err = 1'b0; m_wait = 0; m_stalls = 0; m_flushes = 0;
      for (int c = 0; c < 150; c++) begin
        readAddress1_ID  = 5'($urandom_range(0, 3));
        readAddress2_ID  = 5'($urandom_range(0, 3));
        readAddress1_EX  = 5'($urandom_range(0, 3));
        readAddress2_EX  = 5'($urandom_range(0, 3));
        writeAddress_EX  = 5'($urandom_range(0, 3));
        writeAddress_MEM = 5'($urandom_range(0, 3));
        writeAddress_WB  = 5'($urandom_range(0, 3));
        regWrite_EX  = 1'($urandom_range(0, 1));
        regWrite_MEM = 1'($urandom_range(0, 1));
        regWrite_WB  = 1'($urandom_range(0, 1));
        resultSrc_EX = 2'($urandom_range(0, 3));
        memReq_MEM   = ($urandom_range(0, 3) == 0);
        memReady     = ($urandom_range(0, 9) < 7);
        PCSrc_EX     = ($urandom_range(0, 4) == 0);
        #1;
        mw = (m_wait > 0) ? !memReady : (memReq_MEM && !memReady);
        lu = regWrite_EX && resultSrc_EX == 2'b01 && writeAddress_EX != 5'd0 &&
             (writeAddress_EX == readAddress1_ID || writeAddress_EX == readAddress2_ID);
        if (m_init)        exp = 6'b111100;
        else if (m_err)    exp = 6'b110011;
        else if (mw)       exp = 6'b110010;
        else if (PCSrc_EX) exp = 6'b001100;
        else if (lu)       exp = 6'b110100;
        else               exp = 6'b000000;
        ea = (regWrite_MEM && writeAddress_MEM != 5'd0 && writeAddress_MEM == readAddress1_EX) ? 2'b10 :
             (regWrite_WB && writeAddress_WB != 5'd0 && writeAddress_WB == readAddress1_EX) ? 2'b01 : 2'b00;
        eb = (regWrite_MEM && writeAddress_MEM != 5'd0 && writeAddress_MEM == readAddress2_EX) ? 2'b10 :
             (regWrite_WB && writeAddress_WB != 5'd0 && writeAddress_WB == readAddress2_EX) ? 2'b01 : 2'b00;
        tests++;
        if (ctl !== exp || forwardA_EX !== ea || forwardB_EX !== eb) begin
          fails++;
          $display("FAIL random[%0d.%0d]: ctl=%b fwd=%b/%b expected ctl=%b fwd=%b/%b",
                   r, c, ctl, forwardA_EX, forwardB_EX, exp, ea, eb);
        end
        if (!m_init) begin
          m_stalls  += int'(exp[4]);
          m_flushes += int'(exp[2]);
        end
        if (m_init) m_init = 1'b0;
        else if (!m_err) begin
          if (mw) begin
            m_wait++;
            if (TO > 0 && m_wait > TO) m_err = 1'b1;
          end else begin
            m_wait = 0;
          end
        end
        @(negedge clk);
      end
      #1;
`ifdef HAZARD_PERF_CNT_EN
      es = m_stalls; ef = m_flushes;
`else
      es = 0; ef = 0;
`endif
      tests++;
      if (stallCycles !== PW'(es) || flushCycles !== PW'(ef)) begin
        fails++;
        $display("FAIL random_counters[%0d]: stall=%0d flush=%0d expected %0d/%0d", r, stallCycles, flushCycles, es, ef);
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch_loaduse();
    test_forwarding();
    test_mem_wait();
    test_timeout();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
